// File: rtl/dct_seq_pkg.sv
// Shared types and helpers for the NxN transform sequencer: state encoding,
// parameter legality and sample-address formation.
package dct_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } seq_state_e;

    function automatic bit params_legal(input int log2_n, input int rd_lat, input int mac_lat);
        return (log2_n >= 1) && (log2_n <= 4) &&
               (rd_lat >= 1) && (rd_lat <= 4) &&
               (mac_lat >= 1) && (mac_lat <= 4);
    endfunction

    // Row-major address, or column-major when mode is set; caller truncates to its ADDR_W.
    function automatic logic [7:0] addr_of(input logic [3:0] row, input logic [3:0] col,
                                           input logic mode, input int log2_n);
        logic [7:0] r8;
        logic [7:0] c8;
        r8 = {4'b0, row};
        c8 = {4'b0, col};
        return mode ? ((c8 << log2_n) | r8) : ((r8 << log2_n) | c8);
    endfunction

endpackage

// File: rtl/dct_seq_ctrl_delay.sv
// Fixed-depth shift register with synchronous flush; carries the read strobe
// and first-read flag across the sample-memory latency.
module dct_seq_delay #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dct_seq_ctrl.sv
// Sequencer for the NxN 2-D transform: per output coefficient it issues all N*N
// sample reads, then drains the read/MAC latency and flags the result.
module dct_seq_ctrl
    import dct_seq_pkg::*;
#(
    parameter  int LOG2_N  = 3,
    parameter  int RD_LAT  = 2,
    parameter  int MAC_LAT = 1,
    localparam int ADDR_W  = 2 * LOG2_N
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic              mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] address,
    output logic              mac_en,
    output logic              acc_clr,
    output logic [LOG2_N-1:0] in_row,
    output logic [LOG2_N-1:0] in_col,
    output logic [LOG2_N-1:0] out_row,
    output logic [LOG2_N-1:0] out_col,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    localparam int                DRAIN_LEN = RD_LAT + MAC_LAT;
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

    if (!params_legal(LOG2_N, RD_LAT, MAC_LAT)) begin : g_bad_params
        $error("dct_seq_ctrl: LOG2_N, RD_LAT or MAC_LAT out of range");
    end

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] in_q, in_d;
    logic [ADDR_W-1:0] out_q, out_d;
    logic [3:0]        drain_q, drain_d;
    logic              mode_q, mode_d;
    logic              issue;
    logic              first;
    logic [1:0]        dly_q;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            in_q    <= '0;
            out_q   <= '0;
            drain_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            out_q   <= out_d;
            drain_q <= drain_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        out_d   = out_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        issue   = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    mode_d  = mode;
                    in_d    = '0;
                    out_d   = '0;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    issue = 1'b1;
                    in_d  = in_q + ADDR_W'(1);
                    if (in_q == LAST_IDX) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 4'd1;
                if (drain_q == 4'(DRAIN_LEN - 1)) state_d = RESULT;
            end
            RESULT: begin
                ready = 1'b1;
                out_d = out_q + ADDR_W'(1);
                if (out_q == LAST_IDX) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a start seen in the same cycle.
        if (abort) begin
            state_d = IDLE;
            in_d    = '0;
            out_d   = '0;
            drain_d = '0;
            ready   = 1'b0;
            done    = 1'b0;
        end
    end

    assign first = issue && (in_q == '0);

    // ROM fetch for in_row/in_col shares the read latency, so only the strobes are delayed.
    dct_seq_delay #(
        .WIDTH (2),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk_i   (clk),
        .rst_ni  (rst_in),
        .flush_i (abort),
        .d_i     ({issue, first}),
        .q_o     (dly_q)
    );

    assign rd_en   = issue;
    assign mac_en  = dly_q[1];
    assign acc_clr = dly_q[0];
    assign in_row  = in_q[ADDR_W-1:LOG2_N];
    assign in_col  = in_q[LOG2_N-1:0];
    assign out_row = out_q[ADDR_W-1:LOG2_N];
    assign out_col = out_q[LOG2_N-1:0];
    assign busy    = (state_q != IDLE);
    assign address = ADDR_W'(addr_of(4'(in_row), 4'(in_col), mode_q, LOG2_N));

endmodule

// File: tb/tb_dct_seq_ctrl.sv
// Bench for dct_seq_ctrl: randomized start/hold/mode stimulus compared cycle by
// cycle against an event schedule derived from the block-level timing rules.
module tb_dct_seq_ctrl;

    localparam int LOG2_N  = 3;
    localparam int N       = 8;
    localparam int NN      = 64;
    localparam int RD_LAT  = 2;
    localparam int MAC_LAT = 1;
    localparam int MAXT    = 6000;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic       mode = 1'b0;
    logic       rd_en, mac_en, acc_clr, ready, busy, done;
    logic [5:0] address;
    logic [2:0] in_row, in_col, out_row, out_col;

    int n_vec = 0;
    int n_err = 0;

    bit st_start [MAXT];
    bit st_abort [MAXT];
    bit st_hold  [MAXT];
    bit e_rd [MAXT];
    bit e_mac [MAXT];
    bit e_clr [MAXT];
    bit e_rdy [MAXT];
    bit e_done [MAXT];
    bit e_busy [MAXT];
    int e_addr [MAXT];
    int e_in [MAXT];
    int e_out [MAXT];

    int r_first, r_nrdy, r_done, r_nclr, r_nmac;

    dct_seq_ctrl #(
        .LOG2_N  (LOG2_N),
        .RD_LAT  (RD_LAT),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk     (clk),
        .rst_in  (rst_in),
        .start   (start),
        .abort   (abort),
        .hold    (hold),
        .mode    (mode),
        .rd_en   (rd_en),
        .address (address),
        .mac_en  (mac_en),
        .acc_clr (acc_clr),
        .in_row  (in_row),
        .in_col  (in_col),
        .out_row (out_row),
        .out_col (out_col),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] all_outputs();
        return {rd_en, address, mac_en, acc_clr, in_row, in_col, out_row, out_col,
                ready, busy, done};
    endfunction

    task automatic clear_stim();
        for (int u = 0; u < MAXT; u++) begin
            st_start[u] = 1'b0;
            st_abort[u] = 1'b0;
            st_hold[u]  = 1'b0;
        end
    endtask

    // Expected schedule: cycle 0 carries the start pulse, issue begins at cycle 1.
    task automatic build(input bit md, input int ta, output int tend);
        int t;
        for (int u = 0; u < MAXT; u++) begin
            e_rd[u] = 0; e_mac[u] = 0; e_clr[u] = 0; e_rdy[u] = 0; e_done[u] = 0;
            e_busy[u] = 0; e_addr[u] = 0; e_in[u] = 0; e_out[u] = 0;
        end
        t = 1;
        for (int k = 0; k < NN; k++) begin
            for (int j = 0; j < NN; j++) begin
                while (st_hold[t] && t < MAXT - 16) begin
                    e_busy[t] = 1; e_in[t] = j; e_out[t] = k;
                    t++;
                end
                e_rd[t]   = 1;
                e_addr[t] = md ? (j % N) * N + j / N : j;
                e_in[t]   = j;
                e_out[t]  = k;
                e_busy[t] = 1;
                e_mac[t + RD_LAT] = 1;
                e_clr[t + RD_LAT] = (j == 0);
                t++;
            end
            for (int d = 0; d < RD_LAT + MAC_LAT; d++) begin
                e_busy[t] = 1; e_out[t] = k;
                t++;
            end
            e_busy[t] = 1; e_rdy[t] = 1; e_done[t] = (k == NN - 1); e_out[t] = k;
            t++;
        end
        tend = t - 1;
        if (ta >= 0) begin
            e_rdy[ta]  = 0;
            e_done[ta] = 0;
            for (int u = ta + 1; u < MAXT; u++) begin
                e_rd[u] = 0; e_mac[u] = 0; e_clr[u] = 0; e_rdy[u] = 0; e_done[u] = 0;
                e_busy[u] = 0; e_addr[u] = 0; e_in[u] = 0; e_out[u] = 0;
            end
            tend = ta;
        end
    endtask

    task automatic run_block(input string name, input bit md, input int ta);
        int          tend;
        logic [23:0] got, exp;
        st_start[0] = 1'b1;
        if (ta >= 0) st_abort[ta] = 1'b1;
        build(md, ta, tend);
        for (int t = 1; t < tend; t++)
            if ($urandom_range(0, 99) < 3) st_start[t] = 1'b1;
        r_first = -1; r_nrdy = 0; r_done = -1; r_nclr = 0; r_nmac = 0;
        for (int t = 0; t <= tend + 4; t++) begin
            @(posedge clk);
            #1;
            start = st_start[t];
            abort = st_abort[t];
            hold  = st_hold[t];
            mode  = (t == 0) ? md : 1'($urandom);
            @(negedge clk);
            if (ready) begin
                if (r_first < 0) r_first = t;
                r_nrdy++;
            end
            if (done && r_done < 0) r_done = t;
            if (acc_clr) r_nclr++;
            if (mac_en) r_nmac++;
            got = {rd_en, e_rd[t] ? address : 6'd0, mac_en, acc_clr,
                   e_busy[t] ? {in_row, in_col, out_row, out_col} : 12'd0,
                   ready, busy, done};
            exp = {e_rd[t], e_rd[t] ? 6'(e_addr[t]) : 6'd0, e_mac[t], e_clr[t],
                   e_busy[t] ? {3'(e_in[t] / N), 3'(e_in[t] % N),
                                3'(e_out[t] / N), 3'(e_out[t] % N)} : 12'd0,
                   e_rdy[t], e_busy[t], e_done[t]};
            chk_eq($sformatf("%s@%0d", name, t), 64'(got), 64'(exp));
        end
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_outputs", 64'(all_outputs()), 64'd0);
        rst_in = 1'b1;

        // Plain block, row-major, stray starts while busy.
        clear_stim();
        run_block("plain", 1'b0, -1);
        chk_eq("plain_first_ready", 64'(r_first), 64'd68);
        chk_eq("plain_ready_count", 64'(r_nrdy), 64'd64);
        chk_eq("plain_done_cycle", 64'(r_done), 64'd4352);
        chk_eq("plain_clr_count", 64'(r_nclr), 64'd64);
        chk_eq("plain_mac_count", 64'(r_nmac), 64'd4096);

        // start together with abort while idle.
        clear_stim();
        run_block("idle_abort", 1'b0, 0);
        chk_eq("idle_abort_ready", 64'(r_nrdy), 64'd0);
        chk_eq("idle_abort_mac", 64'(r_nmac), 64'd0);

        // Transposed addressing with random holds everywhere.
        clear_stim();
        for (int u = 0; u < MAXT; u++) st_hold[u] = ($urandom_range(0, 15) == 0);
        run_block("transposed", 1'b1, -1);
        chk_eq("transposed_ready_count", 64'(r_nrdy), 64'd64);
        chk_eq("transposed_clr_count", 64'(r_nclr), 64'd64);
        chk_eq("transposed_mac_count", 64'(r_nmac), 64'd4096);

        // Five-cycle hold at inner 10 of output 0, then abort in output 3 drain.
        clear_stim();
        for (int u = 11; u <= 15; u++) st_hold[u] = 1'b1;
        run_block("hold_abort", 1'b0, 275);
        chk_eq("hold_first_ready", 64'(r_first), 64'd73);
        chk_eq("abort_ready_count", 64'(r_nrdy), 64'd3);
        chk_eq("abort_no_done", 64'(r_done), 64'hFFFF_FFFF_FFFF_FFFF);
        chk_eq("abort_clr_count", 64'(r_nclr), 64'd4);
        chk_eq("abort_mac_count", 64'(r_nmac), 64'd256);

        // Asynchronous reset in the middle of issue.
        @(posedge clk);
        #1 start = 1'b1; mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk_eq("pre_reset_rd_en", 64'(rd_en), 64'd1);
        chk_eq("pre_reset_busy", 64'(busy), 64'd1);
        rst_in = 1'b0;
        #1;
        chk_eq("async_reset_outputs", 64'(all_outputs()), 64'd0);
        @(posedge clk);
        #1 rst_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("post_reset_idle", 64'(all_outputs()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
